round_timer_sequencer: RTL

//  Per-question game sequencer for the binary math game. It owns the count-to-10 tick counter: it clears

---
 rtl/round_timer_sequencer_if.sv | 42 ++++
 rtl/round_timer_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/round_timer_sequencer_if.sv
// round_timer_sequencer_if
//   Bundles the handshake between the game logic, the count-to-10 tick
//   counter and the per-question sequencer.
//   master : game/input logic and counter side (drives the requests and pulses)
//   slave  : round_timer_sequencer (drives the timer controls and game status)
//   Signals:
//     start, second_tick, ten, answer_valid, answer_correct   master -> slave
//     timer_enable, timer_clear_n, new_question, correct,
//     timeout, round, score, lives, game_over                 slave -> master
interface round_timer_sequencer_if #(
    parameter int NUM_ROUNDS = 8,
    parameter int SCORE_W    = 4
);
    localparam int ROUND_W = $clog2(NUM_ROUNDS + 1);

    logic               start;
    logic               second_tick;
    logic               ten;
    logic               answer_valid;
    logic               answer_correct;
    logic               timer_enable;
    logic               timer_clear_n;
    logic               new_question;
    logic               correct;
    logic               timeout;
    logic [ROUND_W-1:0] round;
    logic [SCORE_W-1:0] score;
    logic [1:0]         lives;
    logic               game_over;

    modport master (
        output start, second_tick, ten, answer_valid, answer_correct,
        input  timer_enable, timer_clear_n, new_question, correct, timeout,
               round, score, lives, game_over
    );

    modport slave (
        input  start, second_tick, ten, answer_valid, answer_correct,
        output timer_enable, timer_clear_n, new_question, correct, timeout,
               round, score, lives, game_over
    );
endinterface

// File: rtl/round_timer_sequencer.sv
// round_timer_sequencer
//   Per-question sequencer for the binary math game. Owns the count-to-10
//   tick counter (clears it, gates its enable with the 1 Hz tick, treats its
//   ten pulse as the question timeout), counts rounds and keeps the score.
//   Ports:
//     clk_i    system clock, rising edge
//     rst_n_i  asynchronous active-low reset
//     sif      round_timer_sequencer_if.slave (see interface file)
//   Optional feature macro: GAME_LIVES_EN
//     defined   : lives load LIVES at game start, each timeout costs one,
//                 reaching zero ends the game after the result hold
//     undefined : lives tied to 0, game ends only on the round count
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | after reset, counter cleared, waiting for start
//   ST_LOAD   | one cycle: new operand requested, counter cleared
//   ST_ANSWER | counter running on second_tick, waiting for answer or ten
//   ST_RESULT | counter cleared, holding RESULT_HOLD ticks before advancing
//   ST_DONE   | game over, round/score frozen, waiting for start
module round_timer_sequencer #(
    parameter int NUM_ROUNDS  = 8,
    parameter int SCORE_W     = 4,
    parameter int RESULT_HOLD = 2,
    parameter int LIVES       = 3
) (
    input logic                     clk_i,
    input logic                     rst_n_i,
    round_timer_sequencer_if.slave  sif
);
    localparam int                 ROUND_W    = $clog2(NUM_ROUNDS + 1);
    localparam int                 HOLD_W     = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(RESULT_HOLD - 1);

`ifdef GAME_LIVES_EN
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
`else
    localparam logic [1:0] LIVES_INIT = 2'd0;
    // LIVES only matters when the lives feature is built in.
    logic [1:0] unused_lives;
    assign unused_lives = 2'(LIVES);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ANSWER,
        ST_RESULT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               clear_n_q, clear_n_d;
    logic               new_q_q, new_q_d;
    logic               correct_q, correct_d;
    logic               timeout_q, timeout_d;
    logic               game_over_q, game_over_d;
    logic               game_end;

`ifdef GAME_LIVES_EN
    assign game_end = (round_q == LAST_ROUND) || (lives_q == 2'd0);
`else
    assign game_end = (round_q == LAST_ROUND);
`endif

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        score_d   = score_q;
        lives_d   = lives_q;
        hold_d    = hold_q;
        correct_d = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (sif.start) begin
                    state_d = ST_LOAD;
                    round_d = '0;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            ST_LOAD: begin
                state_d = ST_ANSWER;
            end
            ST_ANSWER: begin
                // An answer arriving with ten in the same cycle wins.
                if (sif.answer_valid) begin
                    state_d = ST_RESULT;
                    hold_d  = HOLD_LOAD;
                    if (sif.answer_correct) begin
                        correct_d = 1'b1;
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                    end else begin
                        timeout_d = 1'b1;
                    end
                end else if (sif.ten) begin
                    state_d   = ST_RESULT;
                    hold_d    = HOLD_LOAD;
                    timeout_d = 1'b1;
                end
            end
            ST_RESULT: begin
                // hold_q counts down; the tick seen at zero is the last one.
                if (sif.second_tick) begin
                    if (hold_q == '0) begin
                        if (game_end) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_LOAD;
                            round_d = round_q + ROUND_W'(1);
                        end
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef GAME_LIVES_EN
        if (timeout_d && (lives_q != 2'd0)) begin
            lives_d = lives_q - 2'd1;
        end
`endif

        new_q_d     = (state_d == ST_LOAD);
        clear_n_d   = (state_d == ST_ANSWER);
        game_over_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            round_q     <= '0;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            hold_q      <= '0;
            clear_n_q   <= 1'b0;
            new_q_q     <= 1'b0;
            correct_q   <= 1'b0;
            timeout_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            hold_q      <= hold_d;
            clear_n_q   <= clear_n_d;
            new_q_q     <= new_q_d;
            correct_q   <= correct_d;
            timeout_q   <= timeout_d;
            game_over_q <= game_over_d;
        end
    end

    // Enable is combinational so the counter sees this cycle's tick; a
    // submitted answer freezes it so ten cannot fire behind the answer.
    assign sif.timer_enable  = (state_q == ST_ANSWER) & sif.second_tick & ~sif.answer_valid;
    assign sif.timer_clear_n = clear_n_q;
    assign sif.new_question  = new_q_q;
    assign sif.correct       = correct_q;
    assign sif.timeout       = timeout_q;
    assign sif.round         = round_q;
    assign sif.score         = score_q;
    assign sif.lives         = lives_q;
    assign sif.game_over     = game_over_q;

endmodule
